// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - MEM-stage data-memory access unit with stall, misalign and timeout handling
module mem_stage_access_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] EXE_MEM_Result,
  input  logic [DATA_W-1:0] EXE_MEM_Rt,
  input  logic [REG_W-1:0]  EXE_MEM_DstReg,
  input  logic              EXE_MEM_MemRead,
  input  logic              EXE_MEM_MemWrite,
  input  logic              EXE_MEM_MemtoReg,
  input  logic              EXE_MEM_RegWrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] MEM_WB_ReadData,
  output logic [DATA_W-1:0] MEM_WB_Result,
  output logic [REG_W-1:0]  MEM_WB_DstReg,
  output logic              MEM_WB_MemtoReg,
  output logic              MEM_WB_RegWrite,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               abort_q, abort_d;
  logic [DATA_W-1:0]  wb_readdata_q, wb_readdata_d;
  logic [DATA_W-1:0]  wb_result_q, wb_result_d;
  logic [REG_W-1:0]   wb_dst_q, wb_dst_d;
  logic               wb_m2r_q, wb_m2r_d;
  logic               wb_rw_q, wb_rw_d;
  logic               err_q, err_d;

  logic op, bad;
  assign op  = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  assign bad = (EXE_MEM_Result[1:0] != 2'b00) | (EXE_MEM_MemRead & EXE_MEM_MemWrite);

  // Next-state, request latching and MEM/WB load selection; MEM/WB defaults to a bubble
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    abort_d       = abort_q;
    wb_readdata_d = '0;
    wb_result_d   = '0;
    wb_dst_d      = '0;
    wb_m2r_d      = 1'b0;
    wb_rw_d       = 1'b0;
    err_d         = 1'b0;
    mem_stall     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op && !bad) begin
          mem_stall = 1'b1;
          state_d   = S_WAIT;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = EXE_MEM_MemWrite;
          addr_d    = EXE_MEM_Result;
          wdata_d   = EXE_MEM_Rt;
          rdata_d   = '0;
          abort_d   = 1'b0;
        end else begin
          wb_result_d = EXE_MEM_Result;
          wb_dst_d    = EXE_MEM_DstReg;
          if (op) begin
            // Rejected access: retire the instruction without a register write
            err_d = 1'b1;
          end else begin
            wb_m2r_d = EXE_MEM_MemtoReg;
            wb_rw_d  = EXE_MEM_RegWrite;
          end
        end
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          // Ack takes priority over a timeout landing in the same cycle
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) rdata_d = dmem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Upstream is still frozen here, so the EXE/MEM inputs belong to this access
        state_d     = S_IDLE;
        wb_result_d = EXE_MEM_Result;
        wb_dst_d    = EXE_MEM_DstReg;
        if (!abort_q) begin
          wb_readdata_d = rdata_q;
          wb_m2r_d      = EXE_MEM_MemtoReg;
          wb_rw_d       = EXE_MEM_RegWrite;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request and MEM/WB registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      abort_q       <= 1'b0;
      wb_readdata_q <= '0;
      wb_result_q   <= '0;
      wb_dst_q      <= '0;
      wb_m2r_q      <= 1'b0;
      wb_rw_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      abort_q       <= abort_d;
      wb_readdata_q <= wb_readdata_d;
      wb_result_q   <= wb_result_d;
      wb_dst_q      <= wb_dst_d;
      wb_m2r_q      <= wb_m2r_d;
      wb_rw_q       <= wb_rw_d;
      err_q         <= err_d;
    end
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign MEM_WB_ReadData = wb_readdata_q;
  assign MEM_WB_Result   = wb_result_q;
  assign MEM_WB_DstReg   = wb_dst_q;
  assign MEM_WB_MemtoReg = wb_m2r_q;
  assign MEM_WB_RegWrite = wb_rw_q;
  assign mem_err         = err_q;

endmodule
